// File: rtl/int_ctrl_if.sv
// ---------------------------------------------------------------------------
// int_ctrl_if
// CPU IO bus bundle used to reach the interrupt controller's registers.
//
// Signals
//   io_rd     CPU read strobe, one cycle wide
//   io_wr     CPU write strobe, one cycle wide
//   io_addr   16-bit IO address; bits 12..8 are one-hot register selects
//   io_wdata  16-bit write data
//   io_rdata  16-bit read data, combinational from the slave
//
// Modports
//   master    the CPU side (drives strobes, address and write data)
//   slave     the interrupt controller (returns read data)
// ---------------------------------------------------------------------------
interface int_ctrl_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  modport master (
    output io_rd,
    output io_wr,
    output io_addr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_rd,
    input  io_wr,
    input  io_addr,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl
// Eight-source interrupt controller: seven edge-triggered external lines plus
// a down-counting Timer1. Events latch into a sticky PEND register
// (write-1-to-clear), are gated by MASK and presented to the CPU as int_rqst.
//
// Ports
//   clk       system clock, all state updates on its rising edge
//   resetq    asynchronous active-low reset
//   bus       CPU IO bus (int_ctrl_if.slave)
//   ext_irq   7 asynchronous external interrupt lines (bit n -> INT_n)
//   int_rqst  8-bit request vector; bit 7 = Timer1, bits 6..0 = ext lines
//
// Register map (address bits are one-hot selects; several may be set at once)
//   io_addr[8]   PEND    8 bits, sticky, write-1-to-clear
//   io_addr[9]   MASK    8 bits, read/write
//   io_addr[10]  RELOAD  16 bits, read/write
//   io_addr[11]  COUNT   16 bits, read/write
//   io_addr[12]  TCTRL   bit 0 = timer enable, bits 15..1 read as 0
// ---------------------------------------------------------------------------
module int_ctrl (
  input  logic             clk,
  input  logic             resetq,
  int_ctrl_if.slave        bus,
  input  logic [6:0]       ext_irq,
  output logic [7:0]       int_rqst
);

  logic [7:0]  r_pend;
  logic [7:0]  r_mask;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic        r_tctrl;

  logic [6:0]  r_sync1;
  logic [6:0]  r_sync2;
  logic [6:0]  r_hist;

  logic        w_selPend;
  logic        w_selMask;
  logic        w_selReload;
  logic        w_selCount;
  logic        w_selTctrl;

  logic        w_wrPend;
  logic        w_wrMask;
  logic        w_wrReload;
  logic        w_wrCount;
  logic        w_wrTctrl;

  logic [6:0]  w_extEdge;
  logic        w_timerEvent;
  logic [7:0]  w_pendSet;
  logic [7:0]  w_pendClr;

  // Reads are ungated by io_rd and only a handful of address bits decode,
  // so these inputs are intentionally left unused.
  logic        w_unused;
  assign w_unused = &{1'b0, bus.io_rd, bus.io_addr[15:13], bus.io_addr[7:0],
                      bus.io_wdata[15:8] & {8{1'b0}}};

  assign w_selPend   = bus.io_addr[8];
  assign w_selMask   = bus.io_addr[9];
  assign w_selReload = bus.io_addr[10];
  assign w_selCount  = bus.io_addr[11];
  assign w_selTctrl  = bus.io_addr[12];

  assign w_wrPend    = bus.io_wr & w_selPend;
  assign w_wrMask    = bus.io_wr & w_selMask;
  assign w_wrReload  = bus.io_wr & w_selReload;
  assign w_wrCount   = bus.io_wr & w_selCount;
  assign w_wrTctrl   = bus.io_wr & w_selTctrl;

  // Rising edge only: synchronised level is high but was low last cycle.
  assign w_extEdge = r_sync2 & ~r_hist;

  // A CPU write to COUNT suppresses the wrap event in that cycle.
  assign w_timerEvent = r_tctrl & (r_count == 16'd0) & ~w_wrCount;

  assign w_pendSet = {w_timerEvent, w_extEdge};
  assign w_pendClr = w_wrPend ? bus.io_wdata[7:0] : 8'h00;

  // Read mux: OR of every selected register, zero when nothing is selected.
  always_comb begin
    bus.io_rdata = 16'h0000;
    if (w_selPend)   bus.io_rdata = bus.io_rdata | {8'h00, r_pend};
    if (w_selMask)   bus.io_rdata = bus.io_rdata | {8'h00, r_mask};
    if (w_selReload) bus.io_rdata = bus.io_rdata | r_reload;
    if (w_selCount)  bus.io_rdata = bus.io_rdata | r_count;
    if (w_selTctrl)  bus.io_rdata = bus.io_rdata | {15'h0000, r_tctrl};
  end

  // Two-flop synchroniser plus a history flop per external line. History
  // resets to 0, so a line already high when reset lifts gives one event.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= ext_irq;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Sticky pending bits; set is OR-ed in after the clear so a same-cycle
  // event beats a write-1-to-clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_pendClr) | w_pendSet;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_mask   <= '0;
      r_reload <= '0;
      r_tctrl  <= 1'b0;
    end else begin
      if (w_wrMask)   r_mask   <= bus.io_wdata[7:0];
      if (w_wrReload) r_reload <= bus.io_wdata;
      if (w_wrTctrl)  r_tctrl  <= bus.io_wdata[0];
    end
  end

  // Timer1: a CPU write wins, otherwise count down and reload on zero.
  // RELOAD is only sampled at the wrap, so writing it mid-count is deferred.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_count <= '0;
    end else if (w_wrCount) begin
      r_count <= bus.io_wdata;
    end else if (r_tctrl) begin
      if (r_count == 16'd0) r_count <= r_reload;
      else                  r_count <= r_count - 16'd1;
    end
  end

  // Both operands are registers, so no io_* input reaches int_rqst.
  assign int_rqst = r_pend & r_mask;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 clk  in  1  system clock; every register updates on its rising edge.
REQ-002 resetq  in  1  asynchronous, active-low reset.
REQ-003 io_rd  in  1  CPU IO read strobe, one cycle wide.
REQ-004 io_wr  in  1  CPU IO write strobe, one cycle wide.
REQ-005 io_addr  in  16  CPU IO address (top of stack).
REQ-006 io_wdata  in  16  CPU IO write data (next on stack).
REQ-007 io_rdata  out  16  read data, combinational, valid in the same cycle as io_rd.
REQ-008 ext_irq  in  7  asynchronous external interrupt lines; bit n feeds INT_n, n=0..6.
REQ-009 int_rqst  out  8  interrupt request vector to the CPU; bit 7 = Timer1, bits 6..0 = external lines.

Function
REQ-010 Register selection SHALL be one-hot on address bits. No other address bits are decoded.
- io_addr[8]: PEND.
- io_addr[9]: MASK.
- io_addr[10]: RELOAD.
- io_addr[11]: COUNT.
- io_addr[12]: TCTRL.
REQ-011 A write SHALL update every register whose select bit is set.
REQ-012 io_rdata SHALL be the bitwise OR of all selected registers, zero-extended, and 0 when none is selected; io_rd does not gate it.
REQ-013 Each ext_irq bit SHALL pass through a 2-flop synchroniser followed by a history flop.
REQ-014 An edge event SHALL be defined as synchronised=1 AND history=0 (rising edge only); levels and falling edges set nothing.
REQ-015 An input rising before clock edge k SHALL set PEND[n] at edge k+2.
REQ-016 PEND (8 bits) SHALL be sticky: set by events, cleared only by writing 1 to that bit (write-1-to-clear); writing 0 has no effect.
REQ-017 If a set event and a clear for the same bit occur in the same cycle, set SHALL win.
REQ-018 MASK (8 bits, read/write) SHALL gate the output: int_rqst = PEND & MASK.
REQ-019 int_rqst SHALL be driven directly from registers, with no combinational path from io_* inputs.
REQ-020 Timer1 counter: COUNT, 16 bits. TCTRL bit 0 = enable; TCTRL bits 15..1 read as 0.
REQ-021 When enabled and COUNT != 0, COUNT SHALL decrement by 1 per clock.
REQ-022 When enabled and COUNT == 0, COUNT SHALL load RELOAD and PEND[7] SHALL be set in the same edge; the period is RELOAD+1 clocks.
REQ-023 RELOAD = 0 with the timer enabled SHALL set PEND[7] every clock.
REQ-024 When disabled, COUNT SHALL hold and no timer event occurs.
REQ-025 A CPU write to COUNT SHALL take priority over decrement and reload; no timer event occurs in that cycle.
REQ-026 A write to RELOAD SHALL not affect COUNT until the next reload.
REQ-027 Masking a pending bit SHALL not clear it; unmasking a pending bit SHALL assert int_rqst on the next clock edge.
REQ-028 All events across the 8 sources are independent; simultaneous events on several lines SHALL all be latched in the same cycle.

Reset
REQ-029 While resetq=0, the following SHALL be held at 0: PEND, MASK, RELOAD, COUNT, TCTRL, all synchroniser flops and all history flops.
REQ-030 While resetq=0, int_rqst SHALL be 0 and io_rdata SHALL depend only on io_addr.
REQ-031 Reset asserted mid-count SHALL clear the count immediately. A line already high at deassertion produces one event, because history resets to 0.

Verification
REQ-032 Edge latency:
- Stimulus: MASK=0x01; ext_irq[0] rises before edge 10.
- Response: int_rqst=0x01 after edge 12; holding ext_irq high 50 cycles produces no further event.
- Stimulus: write PEND=0x01.
- Response: int_rqst=0x00 next cycle.
REQ-033 Timer period:
- Stimulus: RELOAD=4, COUNT=4, TCTRL=1, MASK=0x80.
- Response: PEND[7] sets every 5 clocks; COUNT reads 4,3,2,1,0,4.
REQ-034 Set and clear collide:
- Stimulus: PEND[3] edge event in the same cycle as a write PEND=0x08.
- Response: PEND[3] remains 1.
REQ-035 Masking:
- Stimulus: edges on lines 1 and 5 with MASK=0.
- Response: int_rqst=0, PEND reads 0x22.
- Stimulus: write MASK=0x20.
- Response: int_rqst=0x20.
REQ-036 Multi-select:
- Stimulus: write io_addr=0x0600, io_wdata=0x00FF.
- Response: MASK=0xFF, RELOAD=0x00FF.
- Stimulus: read io_addr=0x0600.
- Response: io_rdata=0x00FF.
REQ-037 Reset mid-operation:
- Stimulus: assert resetq low mid-count with PEND=0xFF.
- Response: all registers read 0 and int_rqst=0 immediately, without waiting for a clock edge.
